id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline boundary of the 5-stage MIPS core, directly downstream of the main decoder.
//  Registers the decoder control bundle together with the register-file operands, the extended immediate and the register addresses.
//  Detects load-use hazards and inserts bubbles, driving the stall to PC/IF-ID.
//  Honours branch flush and global freeze, and counts hazard bubbles for performance debug.
// PARAMETERS
//  DATA_W      32  operand / immediate width
//  RADDR_W     5   register address width
//  CNT_W       16  hazard-bubble counter width (saturating)
// PORTS
//  clk_i          in   1        clock; all state updates on rising edge
//  rst_i          in   1        reset, synchronous, active-low
//  freeze_i       in   1        global stall (memory wait); hold every register
//  flush_i        in   1        branch/jump taken; ID instruction is killed
//  RegDst_i,ALUSrc_i,MemtoReg_i,RegWrite_i,MemWrite_i,MemRead_i  in 1 each  decoder controls
//  ALUOp_i        in   2        0 R-type, 1 add, 2 sub
//  rs_data_i      in   DATA_W   rs read data
//  rt_data_i      in   DATA_W   rt read data
//  imm_i          in   DATA_W   extended immediate
//  rs_addr_i      in   RADDR_W  rs field
//  rt_addr_i      in   RADDR_W  rt field
//  rd_addr_i      in   RADDR_W  rd field
//  funct_i        in   6        funct field
//  <ctrl>_o, ALUOp_o, rs_data_o, rt_data_o, imm_o, rs_addr_o, rt_addr_o, rd_addr_o, funct_o
//                 out  as input  registered copies
//  dst_addr_o     out  RADDR_W  registered write target: RegDst_i ? rd_addr_i : rt_addr_i
//  valid_o        out  1        EX slot holds a real instruction (0 = bubble)
//  hazard_stall_o out  1        comb.; 1 => PC and IF/ID must hold this cycle
//  bubble_cnt_o   out  CNT_W    number of load-use bubbles inserted
// BEHAVIOUR
//  - Reset (rst_i==0 at edge): every registered output 0, valid_o 0, bubble_cnt_o 0. Reset overrides all inputs.
//  - Latency: 1 cycle, ID inputs -> outputs.
//  - hazard_stall_o = valid_o & MemRead_o & (rt_addr_o!=0) & ((rt_addr_o==rs_addr_i) | (rt_addr_o==rt_addr_i)) & ~flush_i.
//  - Priority at each edge, highest first: reset > freeze_i > flush_i > hazard > capture.
//    freeze_i: all registers, including the counter, hold. hazard_stall_o is still driven from held state.
//    flush_i: bubble. All control outputs, data, addresses and dst 0; valid_o 0; counter unchanged.
//    hazard: bubble as for flush; bubble_cnt_o += 1, saturating at all-ones.
//    capture: all *_i registered, valid_o 1.
//  - One bubble resolves a load-use hazard: the next cycle the load is in MEM and valid_o is 0, so the stall drops.
//    Back-to-back stall is impossible without freeze.
//  - flush_i during a hazard: flush wins, no stall, no count (ID instruction is dead).
//  - A bubble never asserts RegWrite_o, MemWrite_o or MemRead_o, independent of RegWrite_i.
//  - Register $0 as load target never stalls.
// STRUCTURE
//  - cpu_pkg holds: ALUOp encodings (ALUOP_RTYPE=0, ALUOP_ADD=1, ALUOP_SUB=2); opcode constants
//    (R 000000, LW 100011, SW 101011, BEQ 000100, J 000010); ctrl-bundle field order/width.
//  - Sub-module hazard_detect: purely combinational load-use comparator producing hazard_stall_o.
//  - Remaining logic is the pipeline register, bubble mux and saturating counter.
// TESTING
//  1. rst_i=0 for 2 cycles with nonzero inputs -> all outputs 0, valid_o 0; then R-type add with rs=1, rt=2, rd=3
//     -> next cycle RegDst_o=1, dst_addr_o=3, ALUOp_o=0, valid_o=1.
//  2. lw $5 followed by add $6,$5,$7 -> hazard_stall_o=1 for exactly one cycle; following EX slot valid_o=0 with all
//     ctrl 0; bubble_cnt_o=1; add then captured.
//  3. lw $0 followed by an instruction using $0 -> hazard_stall_o stays 0, no bubble.
//  4. Load-use pair with flush_i=1 in the same cycle -> hazard_stall_o=0, bubble inserted, bubble_cnt_o unchanged.
//  5. freeze_i=1 for 3 cycles mid-stream with changing inputs -> outputs and counter constant; resume captures current input.
//  6. Force the counter to all-ones (CNT_W=4 build, 16 hazards) -> bubble_cnt_o stays 15.
//     Then rst_i=0 mid-stream -> next edge everything 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared MIPS core definitions: ALU operation encodings, major opcodes and
// the decoder control bundle carried through the ID/EX boundary.
package cpu_pkg;

    typedef enum logic [1:0] {
        ALUOP_RTYPE = 2'd0,
        ALUOP_ADD   = 2'd1,
        ALUOP_SUB   = 2'd2
    } aluop_e;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;

    // Field order MSB..LSB: RegDst, ALUSrc, MemtoReg, RegWrite, MemWrite, MemRead, ALUOp[1:0]
    typedef struct packed {
        logic   reg_dst;
        logic   alu_src;
        logic   memto_reg;
        logic   reg_write;
        logic   mem_write;
        logic   mem_read;
        aluop_e alu_op;
    } ctrl_t;

    localparam int unsigned CTRL_W = $bits(ctrl_t);

    localparam ctrl_t CTRL_BUBBLE = ctrl_t'('0);

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX boundary bundle: decoder-side inputs, EX-side registered outputs,
// plus the pipeline control lines (freeze, flush, stall, bubble count).
interface id_ex_stage_if #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned RADDR_W = 5,
    parameter int unsigned CNT_W   = 16
);
    logic               freeze_i;
    logic               flush_i;

    logic               RegDst_i;
    logic               ALUSrc_i;
    logic               MemtoReg_i;
    logic               RegWrite_i;
    logic               MemWrite_i;
    logic               MemRead_i;
    logic [1:0]         ALUOp_i;
    logic [DATA_W-1:0]  rs_data_i;
    logic [DATA_W-1:0]  rt_data_i;
    logic [DATA_W-1:0]  imm_i;
    logic [RADDR_W-1:0] rs_addr_i;
    logic [RADDR_W-1:0] rt_addr_i;
    logic [RADDR_W-1:0] rd_addr_i;
    logic [5:0]         funct_i;

    logic               RegDst_o;
    logic               ALUSrc_o;
    logic               MemtoReg_o;
    logic               RegWrite_o;
    logic               MemWrite_o;
    logic               MemRead_o;
    logic [1:0]         ALUOp_o;
    logic [DATA_W-1:0]  rs_data_o;
    logic [DATA_W-1:0]  rt_data_o;
    logic [DATA_W-1:0]  imm_o;
    logic [RADDR_W-1:0] rs_addr_o;
    logic [RADDR_W-1:0] rt_addr_o;
    logic [RADDR_W-1:0] rd_addr_o;
    logic [5:0]         funct_o;
    logic [RADDR_W-1:0] dst_addr_o;
    logic               valid_o;
    logic               hazard_stall_o;
    logic [CNT_W-1:0]   bubble_cnt_o;

    // Decoder / pipeline-control side
    modport master (
        output freeze_i, flush_i,
        output RegDst_i, ALUSrc_i, MemtoReg_i, RegWrite_i, MemWrite_i, MemRead_i, ALUOp_i,
        output rs_data_i, rt_data_i, imm_i, rs_addr_i, rt_addr_i, rd_addr_i, funct_i,
        input  RegDst_o, ALUSrc_o, MemtoReg_o, RegWrite_o, MemWrite_o, MemRead_o, ALUOp_o,
        input  rs_data_o, rt_data_o, imm_o, rs_addr_o, rt_addr_o, rd_addr_o, funct_o,
        input  dst_addr_o, valid_o, hazard_stall_o, bubble_cnt_o
    );

    // Pipeline register side
    modport slave (
        input  freeze_i, flush_i,
        input  RegDst_i, ALUSrc_i, MemtoReg_i, RegWrite_i, MemWrite_i, MemRead_i, ALUOp_i,
        input  rs_data_i, rt_data_i, imm_i, rs_addr_i, rt_addr_i, rd_addr_i, funct_i,
        output RegDst_o, ALUSrc_o, MemtoReg_o, RegWrite_o, MemWrite_o, MemRead_o, ALUOp_o,
        output rs_data_o, rt_data_o, imm_o, rs_addr_o, rt_addr_o, rd_addr_o, funct_o,
        output dst_addr_o, valid_o, hazard_stall_o, bubble_cnt_o
    );

endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use comparator: a valid load in EX whose target is read by the
// instruction in ID forces one bubble. $0 never stalls; a flush kills the
// ID instruction so no stall is needed.
module hazard_detect #(
    parameter int unsigned RADDR_W = 5
) (
    input  logic               ex_valid_i,
    input  logic               ex_mem_read_i,
    input  logic [RADDR_W-1:0] ex_rt_addr_i,
    input  logic [RADDR_W-1:0] id_rs_addr_i,
    input  logic [RADDR_W-1:0] id_rt_addr_i,
    input  logic               flush_i,
    output logic               hazard_stall_o
);

    // Compare the EX load target against both ID source fields
    always_comb begin
        hazard_stall_o = ex_valid_i & ex_mem_read_i & (ex_rt_addr_i != '0)
                       & ((ex_rt_addr_i == id_rs_addr_i) | (ex_rt_addr_i == id_rt_addr_i))
                       & ~flush_i;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the 5-stage MIPS core. Captures the decoder
// controls and operands, inserts bubbles on flush or load-use hazard, holds
// everything on freeze, and counts hazard bubbles (saturating).
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned RADDR_W = 5,
    parameter int unsigned CNT_W   = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    id_ex_stage_if.slave  bus
);

    ctrl_t              ctrl_q,     ctrl_d,     ctrl_in;
    logic [DATA_W-1:0]  rs_data_q,  rs_data_d;
    logic [DATA_W-1:0]  rt_data_q,  rt_data_d;
    logic [DATA_W-1:0]  imm_q,      imm_d;
    logic [RADDR_W-1:0] rs_addr_q,  rs_addr_d;
    logic [RADDR_W-1:0] rt_addr_q,  rt_addr_d;
    logic [RADDR_W-1:0] rd_addr_q,  rd_addr_d;
    logic [5:0]         funct_q,    funct_d;
    logic [RADDR_W-1:0] dst_addr_q, dst_addr_d;
    logic               valid_q,    valid_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic               hazard_stall;

    // Pack the decoder controls into the bundle carried through the stage
    always_comb begin
        ctrl_in           = CTRL_BUBBLE;
        ctrl_in.reg_dst   = bus.RegDst_i;
        ctrl_in.alu_src   = bus.ALUSrc_i;
        ctrl_in.memto_reg = bus.MemtoReg_i;
        ctrl_in.reg_write = bus.RegWrite_i;
        ctrl_in.mem_write = bus.MemWrite_i;
        ctrl_in.mem_read  = bus.MemRead_i;
        ctrl_in.alu_op    = aluop_e'(bus.ALUOp_i);
    end

    hazard_detect #(
        .RADDR_W (RADDR_W)
    ) u_hazard_detect (
        .ex_valid_i     (valid_q),
        .ex_mem_read_i  (ctrl_q.mem_read),
        .ex_rt_addr_i   (rt_addr_q),
        .id_rs_addr_i   (bus.rs_addr_i),
        .id_rt_addr_i   (bus.rt_addr_i),
        .flush_i        (bus.flush_i),
        .hazard_stall_o (hazard_stall)
    );

    // Next-state selection: freeze > flush > hazard bubble > capture
    always_comb begin
        ctrl_d     = ctrl_q;
        rs_data_d  = rs_data_q;
        rt_data_d  = rt_data_q;
        imm_d      = imm_q;
        rs_addr_d  = rs_addr_q;
        rt_addr_d  = rt_addr_q;
        rd_addr_d  = rd_addr_q;
        funct_d    = funct_q;
        dst_addr_d = dst_addr_q;
        valid_d    = valid_q;
        cnt_d      = cnt_q;
        if (bus.freeze_i) begin
            // hold everything
        end else if (bus.flush_i || hazard_stall) begin
            ctrl_d     = CTRL_BUBBLE;
            rs_data_d  = '0;
            rt_data_d  = '0;
            imm_d      = '0;
            rs_addr_d  = '0;
            rt_addr_d  = '0;
            rd_addr_d  = '0;
            funct_d    = '0;
            dst_addr_d = '0;
            valid_d    = 1'b0;
            // hazard_stall is already masked by flush, so only real load-use bubbles count
            if (hazard_stall && !(&cnt_q)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            ctrl_d     = ctrl_in;
            rs_data_d  = bus.rs_data_i;
            rt_data_d  = bus.rt_data_i;
            imm_d      = bus.imm_i;
            rs_addr_d  = bus.rs_addr_i;
            rt_addr_d  = bus.rt_addr_i;
            rd_addr_d  = bus.rd_addr_i;
            funct_d    = bus.funct_i;
            dst_addr_d = bus.RegDst_i ? bus.rd_addr_i : bus.rt_addr_i;
            valid_d    = 1'b1;
        end
    end

    // Pipeline register with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            ctrl_q     <= CTRL_BUBBLE;
            rs_data_q  <= '0;
            rt_data_q  <= '0;
            imm_q      <= '0;
            rs_addr_q  <= '0;
            rt_addr_q  <= '0;
            rd_addr_q  <= '0;
            funct_q    <= '0;
            dst_addr_q <= '0;
            valid_q    <= 1'b0;
            cnt_q      <= '0;
        end else begin
            ctrl_q     <= ctrl_d;
            rs_data_q  <= rs_data_d;
            rt_data_q  <= rt_data_d;
            imm_q      <= imm_d;
            rs_addr_q  <= rs_addr_d;
            rt_addr_q  <= rt_addr_d;
            rd_addr_q  <= rd_addr_d;
            funct_q    <= funct_d;
            dst_addr_q <= dst_addr_d;
            valid_q    <= valid_d;
            cnt_q      <= cnt_d;
        end
    end

    // Drive the registered state onto the EX side of the bundle
    always_comb begin
        bus.RegDst_o       = ctrl_q.reg_dst;
        bus.ALUSrc_o       = ctrl_q.alu_src;
        bus.MemtoReg_o     = ctrl_q.memto_reg;
        bus.RegWrite_o     = ctrl_q.reg_write;
        bus.MemWrite_o     = ctrl_q.mem_write;
        bus.MemRead_o      = ctrl_q.mem_read;
        bus.ALUOp_o        = ctrl_q.alu_op;
        bus.rs_data_o      = rs_data_q;
        bus.rt_data_o      = rt_data_q;
        bus.imm_o          = imm_q;
        bus.rs_addr_o      = rs_addr_q;
        bus.rt_addr_o      = rt_addr_q;
        bus.rd_addr_o      = rd_addr_q;
        bus.funct_o        = funct_q;
        bus.dst_addr_o     = dst_addr_q;
        bus.valid_o        = valid_q;
        bus.hazard_stall_o = hazard_stall;
        bus.bubble_cnt_o   = cnt_q;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Table-driven bench for id_ex_stage (4-bit bubble counter build). Each row
// gives the ID-side inputs plus hand-derived stall, valid and counter values;
// the expected EX-side record is queued when the row is driven and compared
// one cycle later.
module tb_id_ex_stage;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned RADDR_W = 5;
    localparam int unsigned CNT_W   = 4;

    // {RegDst, ALUSrc, MemtoReg, RegWrite, MemWrite, MemRead, ALUOp[1:0]}
    localparam logic [7:0] C_R  = 8'b1_0_0_1_0_0_00;
    localparam logic [7:0] C_LW = 8'b0_1_1_1_0_1_01;
    localparam logic [7:0] C_SW = 8'b0_1_0_0_1_0_01;

    typedef struct {
        logic       rst;
        logic       frz;
        logic       fl;
        logic [7:0] ctrl;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic       chk_s;
        logic       exp_stall;
        logic       exp_valid;
        logic [3:0] exp_cnt;
    } vec_t;

    typedef struct {
        logic [7:0]  ctrl;
        logic [95:0] data;
        logic [25:0] addr;
        logic        valid;
        logic [3:0]  cnt;
    } out_t;

    logic clk;
    logic rst_n;

    vec_t vecs[$];
    out_t sb[$];
    out_t prev;
    int   pass_cnt;
    int   total_cnt;
    int   cur;

    id_ex_stage_if #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .CNT_W(CNT_W)) bus ();

    id_ex_stage #(
        .DATA_W  (DATA_W),
        .RADDR_W (RADDR_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s row %0d: got %h expected %h", nm, cur, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic frz, input logic fl, input logic [7:0] ctrl,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic chk_s, input logic st, input logic v, input logic [3:0] cnt);
        vec_t e;
        e.rst = rst; e.frz = frz; e.fl = fl; e.ctrl = ctrl;
        e.rs = rs; e.rt = rt; e.rd = rd;
        e.chk_s = chk_s; e.exp_stall = st; e.exp_valid = v; e.exp_cnt = cnt;
        vecs.push_back(e);
    endtask

    task automatic compare_pop();
        out_t e;
        e = sb.pop_front();
        check("ctrl", 128'({bus.RegDst_o, bus.ALUSrc_o, bus.MemtoReg_o, bus.RegWrite_o,
                            bus.MemWrite_o, bus.MemRead_o, bus.ALUOp_o}), 128'(e.ctrl));
        check("data", 128'({bus.rs_data_o, bus.rt_data_o, bus.imm_o}), 128'(e.data));
        check("addr", 128'({bus.rs_addr_o, bus.rt_addr_o, bus.rd_addr_o, bus.funct_o,
                            bus.dst_addr_o}), 128'(e.addr));
        check("valid", 128'(bus.valid_o), 128'(e.valid));
        check("bubble_cnt", 128'(bus.bubble_cnt_o), 128'(e.cnt));
    endtask

    initial begin
        vec_t  v;
        out_t  e;
        logic [5:0]  fn;
        logic [31:0] rsd, rtd, imd;

        pass_cnt  = 0;
        total_cnt = 0;
        cur       = 0;
        prev      = '{default: '0};

        rst_n          = 1'b0;
        bus.freeze_i   = 1'b0;
        bus.flush_i    = 1'b0;
        bus.RegDst_i   = 1'b0;
        bus.ALUSrc_i   = 1'b0;
        bus.MemtoReg_i = 1'b0;
        bus.RegWrite_i = 1'b0;
        bus.MemWrite_i = 1'b0;
        bus.MemRead_i  = 1'b0;
        bus.ALUOp_i    = '0;
        bus.rs_data_i  = '0;
        bus.rt_data_i  = '0;
        bus.imm_i      = '0;
        bus.rs_addr_i  = '0;
        bus.rt_addr_i  = '0;
        bus.rd_addr_i  = '0;
        bus.funct_i    = '0;

        //   rst frz fl ctrl  rs  rt  rd  chk stall valid cnt
        add(0, 0, 0, C_R,   1,  2,  3, 0, 0, 0, 0);   // reset, nonzero inputs
        add(0, 0, 0, C_LW,  4,  5,  6, 1, 0, 0, 0);   // second reset cycle
        add(1, 0, 0, C_R,   1,  2,  3, 1, 0, 1, 0);   // add $3,$1,$2
        add(1, 0, 0, C_LW,  1,  5,  0, 1, 0, 1, 0);   // lw $5
        add(1, 0, 0, C_R,   5,  7,  6, 1, 1, 0, 1);   // add $6,$5,$7 -> bubble
        add(1, 0, 0, C_R,   5,  7,  6, 1, 0, 1, 1);   // held add captured
        add(1, 0, 0, C_LW,  1,  0,  0, 1, 0, 1, 1);   // lw $0
        add(1, 0, 0, C_R,   0,  0,  8, 1, 0, 1, 1);   // uses $0, no stall
        add(1, 0, 0, C_LW,  2,  9,  0, 1, 0, 1, 1);   // lw $9
        add(1, 0, 1, C_R,   9,  4, 10, 1, 0, 0, 1);   // use of $9 flushed
        add(1, 0, 0, C_R,   3,  4, 11, 1, 0, 1, 1);
        add(1, 0, 0, C_LW,  3, 12,  0, 1, 0, 1, 1);   // lw $12
        add(1, 1, 0, C_R,  12,  1, 13, 1, 1, 1, 1);   // freeze, stall from held lw
        add(1, 1, 0, C_R,  12,  2, 14, 1, 1, 1, 1);
        add(1, 1, 0, C_SW,  4, 15,  0, 1, 0, 1, 1);
        add(1, 0, 0, C_R,   2,  3, 16, 1, 0, 1, 1);   // resume captures current
        for (int k = 0; k < 16; k++) begin
            add(1, 0, 0, C_LW, 1, 5, 0, 1, 0, 1, 4'((k + 1 > 15) ? 15 : k + 1));
            add(1, 0, 0, C_R,  6, 5, 7, 1, 1, 0, 4'((k + 2 > 15) ? 15 : k + 2));
        end
        add(1, 0, 0, C_R,   1,  2,  3, 1, 0, 1, 15);  // saturated counter holds
        add(0, 0, 0, C_LW,  5,  5,  0, 1, 0, 0, 0);   // mid-stream reset
        add(1, 0, 0, C_R,   1,  2,  3, 1, 0, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            @(negedge clk);
            if (sb.size() != 0) compare_pop();
            cur = i;
            fn  = 6'(i) | 6'h20;
            rsd = 32'hA000_0000 + 32'(i);
            rtd = 32'hB000_0000 + 32'(i);
            imd = 32'hC000_0000 + 32'(i);

            rst_n          = v.rst;
            bus.freeze_i   = v.frz;
            bus.flush_i    = v.fl;
            bus.RegDst_i   = v.ctrl[7];
            bus.ALUSrc_i   = v.ctrl[6];
            bus.MemtoReg_i = v.ctrl[5];
            bus.RegWrite_i = v.ctrl[4];
            bus.MemWrite_i = v.ctrl[3];
            bus.MemRead_i  = v.ctrl[2];
            bus.ALUOp_i    = v.ctrl[1:0];
            bus.rs_addr_i  = v.rs;
            bus.rt_addr_i  = v.rt;
            bus.rd_addr_i  = v.rd;
            bus.funct_i    = fn;
            bus.rs_data_i  = rsd;
            bus.rt_data_i  = rtd;
            bus.imm_i      = imd;

            #1;
            if (v.chk_s) check("hazard_stall", 128'(bus.hazard_stall_o), 128'(v.exp_stall));

            if (!v.rst) begin
                e = '{default: '0};
            end else if (v.frz) begin
                e = prev;
            end else if (v.exp_valid) begin
                e.ctrl = v.ctrl;
                e.data = {rsd, rtd, imd};
                e.addr = {v.rs, v.rt, v.rd, fn, (v.ctrl[7] ? v.rd : v.rt)};
            end else begin
                e = '{default: '0};
            end
            e.valid = v.exp_valid;
            e.cnt   = v.exp_cnt;
            sb.push_back(e);
            prev = e;
        end

        @(negedge clk);
        cur = int'(vecs.size());
        if (sb.size() != 0) compare_pop();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
